// File: rtl/rubiks_pkg.sv
// Shared types and constants for the move-list receive path and its UART receiver.
package rubiks_pkg;

    typedef enum logic [3:0] {
        INICIAL      = 4'd0,
        ENVIA_PEDIDO = 4'd1,
        AGUARDA_BYTE = 4'd2,
        DECODIFICA   = 4'd3,
        GRAVA        = 4'd4,
        FINAL        = 4'd5
    } estado_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DADOS,
        RX_STOP,
        RX_ESPERA
    } rx_estado_t;

    localparam logic [7:0] REQ_BYTE         = 8'h4D;
    localparam logic [7:0] TERM_BYTE        = 8'h23;
    localparam logic [7:0] MOV_BASE         = 8'h30;
    localparam int         N_MOV_CODES      = 6;
    localparam int         CLKS_PER_BIT_DEF = 5208;

    function automatic logic mov_valido(input logic [7:0] b);
        return (b >= MOV_BASE) && (b < MOV_BASE + 8'(N_MOV_CODES));
    endfunction

    function automatic logic [2:0] mov_codigo(input logic [7:0] b);
        return 3'(b - MOV_BASE);
    endfunction

endpackage

// File: rtl/uart_rx_8n1.sv
// 8N1 UART receiver: synchronised input, half-bit start check, centre sampling,
// one-cycle pronto per good frame; frames with a low stop bit are discarded.
module uart_rx_8n1
    import rubiks_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] dado,
    output logic       pronto
);
    localparam int            CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] ULT  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] MEIO = CW'((CLKS_PER_BIT - 1) / 2);

    rx_estado_t    estado, prox;
    logic          rx_m, rx_s;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    idx, idx_n;
    logic [7:0]    sh, sh_n, dado_n;
    logic          pronto_n;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rx_m   <= 1'b1;
            rx_s   <= 1'b1;
            estado <= RX_IDLE;
            cnt    <= '0;
            idx    <= '0;
            sh     <= '0;
            dado   <= '0;
            pronto <= 1'b0;
        end else begin
            rx_m   <= rx;
            rx_s   <= rx_m;
            estado <= prox;
            cnt    <= cnt_n;
            idx    <= idx_n;
            sh     <= sh_n;
            dado   <= dado_n;
            pronto <= pronto_n;
        end
    end

    always_comb begin
        prox     = estado;
        cnt_n    = cnt;
        idx_n    = idx;
        sh_n     = sh;
        dado_n   = dado;
        pronto_n = 1'b0;
        case (estado)
            RX_IDLE: begin
                cnt_n = '0;
                idx_n = '0;
                if (!rx_s) prox = RX_START;
            end
            RX_START: begin
                if (cnt == MEIO) begin
                    cnt_n = '0;
                    prox  = rx_s ? RX_IDLE : RX_DADOS;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            RX_DADOS: begin
                if (cnt == ULT) begin
                    cnt_n = '0;
                    sh_n  = {rx_s, sh[7:1]};
                    idx_n = idx + 3'd1;
                    if (idx == 3'd7) prox = RX_STOP;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            RX_STOP: begin
                if (cnt == ULT) begin
                    cnt_n = '0;
                    if (rx_s) begin
                        dado_n   = sh;
                        pronto_n = 1'b1;
                        prox     = RX_IDLE;
                    end else begin
                        prox = RX_ESPERA;
                    end
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            // Framing error: hold off until the line idles so the low stop bit is not taken as a new start.
            RX_ESPERA: if (rx_s) prox = RX_IDLE;
            default:   prox = RX_IDLE;
        endcase
    end

endmodule

// File: rtl/recebe_movimentos.sv
// Requests the solution move list over UART and writes each decoded move code
// into the move RAM, stopping on the terminator byte or when the RAM is full.
module recebe_movimentos
    import rubiks_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter int MAX_MOV      = 480,
    parameter int N_ADDR       = 9
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              iniciar,
    input  logic              rx_serial,
    output logic              saida_serial,
    output logic [N_ADDR-1:0] addr_movimento,
    output logic [2:0]        data_movimento,
    output logic              we_movimento,
    output logic              conta_movimento,
    output logic [N_ADDR-1:0] num_movimentos,
    output logic              pronto,
    output logic              erro,
    output logic [3:0]        db_estado
);
    localparam int                CW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0]     TX_ULT   = CW'(CLKS_PER_BIT - 1);
    localparam logic [N_ADDR-1:0] ADDR_MAX = N_ADDR'(MAX_MOV);

    estado_t           estado, prox;
    logic [7:0]        rx_dado, byte_lat;
    logic              rx_pronto;
    logic [9:0]        tx_sh;
    logic [CW-1:0]     tx_cnt;
    logic [3:0]        tx_bits;
    logic [N_ADDR-1:0] addr;
    logic              tx_fim, cheio;

    uart_rx_8n1 #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clock  (clock),
        .reset  (reset),
        .rx     (rx_serial),
        .dado   (rx_dado),
        .pronto (rx_pronto)
    );

    assign tx_fim = (tx_bits == 4'd9) && (tx_cnt == TX_ULT);
    assign cheio  = (addr == ADDR_MAX);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) estado <= INICIAL;
        else       estado <= prox;
    end

    always_comb begin
        prox            = estado;
        we_movimento    = 1'b0;
        conta_movimento = 1'b0;
        case (estado)
            INICIAL, FINAL: if (iniciar) prox = ENVIA_PEDIDO;
            ENVIA_PEDIDO:   if (tx_fim) prox = AGUARDA_BYTE;
            AGUARDA_BYTE:   if (rx_pronto) prox = DECODIFICA;
            DECODIFICA: begin
                if (mov_valido(byte_lat))       prox = GRAVA;
                else if (byte_lat == TERM_BYTE) prox = FINAL;
                else                            prox = AGUARDA_BYTE;
            end
            GRAVA: begin
                we_movimento    = !cheio;
                conta_movimento = !cheio;
                prox            = cheio ? FINAL : AGUARDA_BYTE;
            end
            default: prox = INICIAL;
        endcase
    end

    // Datapath: request shifter (stop, data, start framed LSB first), byte latch, address and error flag.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            saida_serial   <= 1'b1;
            tx_sh          <= '1;
            tx_cnt         <= '0;
            tx_bits        <= '0;
            byte_lat       <= '0;
            data_movimento <= '0;
            addr           <= '0;
            erro           <= 1'b0;
        end else begin
            saida_serial <= 1'b1;
            case (estado)
                INICIAL, FINAL: begin
                    if (iniciar) begin
                        addr    <= '0;
                        erro    <= 1'b0;
                        tx_sh   <= {1'b1, REQ_BYTE, 1'b0};
                        tx_cnt  <= '0;
                        tx_bits <= '0;
                    end
                end
                ENVIA_PEDIDO: begin
                    saida_serial <= tx_sh[0];
                    if (tx_cnt == TX_ULT) begin
                        tx_cnt  <= '0;
                        tx_sh   <= {1'b1, tx_sh[9:1]};
                        tx_bits <= tx_bits + 4'd1;
                    end else begin
                        tx_cnt <= tx_cnt + CW'(1);
                    end
                end
                AGUARDA_BYTE: if (rx_pronto) byte_lat <= rx_dado;
                DECODIFICA: begin
                    if (mov_valido(byte_lat))       data_movimento <= mov_codigo(byte_lat);
                    else if (byte_lat != TERM_BYTE) erro <= 1'b1;
                end
                GRAVA: begin
                    if (cheio) erro <= 1'b1;
                    else       addr <= addr + N_ADDR'(1);
                end
                default: ;
            endcase
        end
    end

    assign addr_movimento = addr;
    assign num_movimentos = addr;
    assign pronto         = (estado == FINAL);
    assign db_estado      = estado;

endmodule

// File: tb/tb_recebe_movimentos.sv
// Directed bench: expected RAM writes and completion results go into queues,
// a negedge monitor pops and compares whenever the DUT strobes or finishes.
module tb_recebe_movimentos;
    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       iniciar = 1'b0;
    logic       rx = 1'b1;
    logic       saida_serial;
    logic [8:0] addr_movimento, num_movimentos;
    logic [2:0] data_movimento;
    logic       we_movimento, conta_movimento, pronto, erro;
    logic [3:0] db_estado;

    typedef struct { int a; int d; } wr_t;
    typedef struct { int n; int e; } fin_t;
    wr_t  wq[$];
    fin_t fq[$];
    int   checks = 0;
    int   errors = 0;
    logic pronto_q = 1'b0;

    recebe_movimentos #(.CLKS_PER_BIT(CPB), .MAX_MOV(480), .N_ADDR(9)) dut (
        .clock           (clk),
        .reset           (rst),
        .iniciar         (iniciar),
        .rx_serial       (rx),
        .saida_serial    (saida_serial),
        .addr_movimento  (addr_movimento),
        .data_movimento  (data_movimento),
        .we_movimento    (we_movimento),
        .conta_movimento (conta_movimento),
        .num_movimentos  (num_movimentos),
        .pronto          (pronto),
        .erro            (erro),
        .db_estado       (db_estado)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (we_movimento) begin
            if (wq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL extra_write: addr %0d data %0d with no write expected", addr_movimento, data_movimento);
            end else begin
                wr_t e;
                e = wq.pop_front();
                chk("write_addr", 32'(addr_movimento), 32'(e.a));
                chk("write_data", 32'(data_movimento), 32'(e.d));
                chk("write_conta", 32'(conta_movimento), 32'd1);
            end
        end
        if (pronto && !pronto_q) begin
            if (fq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL extra_pronto: num %0d erro %0d with no completion expected", num_movimentos, erro);
            end else begin
                fin_t f;
                f = fq.pop_front();
                chk("final_num", 32'(num_movimentos), 32'(f.n));
                chk("final_erro", 32'(erro), 32'(f.e));
            end
        end
        pronto_q = pronto;
    end

    task automatic send_byte(input logic [7:0] b, input logic stopb);
        logic [9:0] fr;
        fr = {stopb, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx = fr[i];
            repeat (CPB) @(negedge clk);
        end
        rx = 1'b1;
        repeat (2 * CPB) @(negedge clk);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b1);
    endtask

    task automatic do_start(input bit chk_frame);
        int         n;
        logic [7:0] b;
        @(negedge clk) iniciar = 1'b1;
        @(negedge clk) iniciar = 1'b0;
        chk("estado_envia", 32'(db_estado), 32'd1);
        chk("erro_cleared", 32'(erro), 32'd0);
        chk("addr_cleared", 32'(addr_movimento), 32'd0);
        if (chk_frame) begin
            chk("tx_idle_at_k", 32'(saida_serial), 32'd1);
            n = 0;
            while (saida_serial && n < 4) begin @(negedge clk); n++; end
            chk("tx_start_found", 32'(saida_serial), 32'd0);
            repeat (CPB / 2) @(negedge clk);
            chk("tx_start_bit", 32'(saida_serial), 32'd0);
            for (int i = 0; i < 8; i++) begin
                repeat (CPB) @(negedge clk);
                b[i] = saida_serial;
            end
            chk("tx_req_byte", 32'(b), 32'h4D);
            repeat (CPB) @(negedge clk);
            chk("tx_stop_bit", 32'(saida_serial), 32'd1);
        end
        n = 0;
        while (db_estado != 4'd2 && n < 12 * CPB) begin @(negedge clk); n++; end
        chk("estado_aguarda", 32'(db_estado), 32'd2);
    endtask

    task automatic wait_pronto(input string nm);
        int n;
        n = 0;
        while (!pronto && n < 40 * CPB) begin @(negedge clk); n++; end
        chk(nm, 32'(pronto), 32'd1);
        @(negedge clk);
        chk({nm, "_wq_empty"}, 32'(wq.size()), 32'd0);
        chk({nm, "_fq_empty"}, 32'(fq.size()), 32'd0);
    endtask

    task automatic chk_reset_vals(input string nm);
        chk({nm, "_saida"}, 32'(saida_serial), 32'd1);
        chk({nm, "_pronto"}, 32'(pronto), 32'd0);
        chk({nm, "_erro"}, 32'(erro), 32'd0);
        chk({nm, "_we"}, 32'(we_movimento), 32'd0);
        chk({nm, "_conta"}, 32'(conta_movimento), 32'd0);
        chk({nm, "_addr"}, 32'(addr_movimento), 32'd0);
        chk({nm, "_data"}, 32'(data_movimento), 32'd0);
        chk({nm, "_num"}, 32'(num_movimentos), 32'd0);
        chk({nm, "_estado"}, 32'(db_estado), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [9:0] fr;
        repeat (3) @(negedge clk);
        chk_reset_vals("rst");
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // "035#": three moves then terminator
        do_start(1'b1);
        wq.push_back('{0, 0}); wq.push_back('{1, 3}); wq.push_back('{2, 5});
        fq.push_back('{3, 0});
        send_str("035#");
        wait_pronto("t1");

        // "2X4#": invalid byte raises erro but is skipped
        do_start(1'b0);
        wq.push_back('{0, 2}); wq.push_back('{1, 4});
        fq.push_back('{2, 1});
        send_str("2X4#");
        wait_pronto("t2");

        // 481 x "1": RAM fills, the last byte overflows
        do_start(1'b0);
        for (int i = 0; i < 480; i++) wq.push_back('{i, 1});
        fq.push_back('{480, 1});
        for (int i = 0; i < 481; i++) send_byte(8'h31, 1'b1);
        wait_pronto("t3");
        chk("t3_num", 32'(num_movimentos), 32'd480);

        // reset during the second received byte
        do_start(1'b0);
        wq.push_back('{0, 2});
        send_byte(8'h32, 1'b1);
        chk("t4_addr_before", 32'(addr_movimento), 32'd1);
        fr = {1'b1, 8'h31, 1'b0};
        for (int i = 0; i < 4; i++) begin
            rx = fr[i];
            repeat (CPB) @(negedge clk);
        end
        #2 rst = 1'b1;
        #1 chk_reset_vals("midrst");
        rx = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        do_start(1'b0);
        wq.push_back('{0, 3});
        fq.push_back('{1, 0});
        send_str("3#");
        wait_pronto("t4");

        // "4" with a low stop bit is dropped; "1" lands at the same address
        do_start(1'b0);
        wq.push_back('{0, 1});
        fq.push_back('{1, 0});
        send_byte(8'h34, 1'b0);
        chk("t5_addr_after_bad", 32'(addr_movimento), 32'd0);
        send_str("1#");
        wait_pronto("t5");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/recebe_movimentos.md
# recebe_movimentos

Receives the solution move list from the host solver over the serial link and writes it, one 3-bit move code per entry, into the move RAM that the servo manager later replays. Sits directly upstream of `ram_movimentos`/`gerenciador_servos` in `rubiks_polibot_fd`. On `iniciar` it sends a one-byte request on its serial output, then decodes incoming UART bytes until a terminator arrives or the RAM is full.

## Interface
Parameters:
- `CLKS_PER_BIT`, 5208, clock cycles per UART bit (50 MHz / 9600 baud, 8N1).
- `MAX_MOV`, 480, move RAM depth.
- `N_ADDR`, 9, address width.

Ports:
- `clock`  in  1  system clock; the block uses this single clock.
- `reset`  in  1  reset, asynchronous and active-high.
- `iniciar`  in  1  start pulse; ignored unless the FSM is in INICIAL or FINAL.
- `rx_serial`  in  1  UART receive line; idles high.
- `saida_serial`  out  1  UART transmit line; idles high.
- `addr_movimento`  out  N_ADDR  write address, equal to the number of moves stored so far.
- `data_movimento`  out  3  decoded move code.
- `we_movimento`  out  1  RAM write strobe, 1 cycle.
- `conta_movimento`  out  1  address counter increment, same cycle as `we_movimento`.
- `num_movimentos`  out  N_ADDR  total moves stored, valid when `pronto`=1.
- `pronto`  out  1  high while in FINAL.
- `erro`  out  1  sticky flag for an invalid byte or overflow; cleared by `iniciar`.
- `db_estado`  out  4  current state code, for debug.

## Operation
- States and codes:
  - INICIAL (0): idle.
  - ENVIA_PEDIDO (1): transmit the request byte.
  - AGUARDA_BYTE (2): wait for the next received byte.
  - DECODIFICA (3): classify the byte.
  - GRAVA (4): write one move.
  - FINAL (5): done.
- INICIAL or FINAL + `iniciar` → ENVIA_PEDIDO. On entry: clear the address counter and `erro`, and load the transmit shifter with 0x4D ('M').
- ENVIA_PEDIDO: send 8N1 frame, LSB first. When the stop bit ends → AGUARDA_BYTE.
- AGUARDA_BYTE: on the `uart_rx_8n1` `pronto` pulse, latch the byte → DECODIFICA.
- DECODIFICA:
  - 0x30–0x35 ('0'–'5') → code = byte − 0x30 → GRAVA.
  - 0x23 ('#') → FINAL.
  - Any other byte → set `erro`, discard the byte → AGUARDA_BYTE.
- GRAVA:
  - If address < MAX_MOV: assert `we_movimento` and `conta_movimento` for 1 cycle, increment address → AGUARDA_BYTE.
  - If address = MAX_MOV: no write, set `erro` → FINAL.
- FINAL: `pronto`=1 and `num_movimentos`=address; hold until `iniciar` or `reset`.
- Bytes arriving outside AGUARDA_BYTE are dropped. The receiver's single `pronto` pulse is not queued.
- Reset values: `saida_serial`=1; `pronto`, `erro`, `we_movimento` and `conta_movimento`=0; `addr_movimento`, `data_movimento` and `num_movimentos`=0; state INICIAL.
- Reset during any state aborts immediately to INICIAL. No partial write strobe is emitted.

## Timing
- `iniciar` sampled at edge k → start bit on `saida_serial` from edge k+1. Request frame lasts 10·CLKS_PER_BIT cycles.
- Receiver `pronto` at edge n → DECODIFICA at n+1 → GRAVA at n+2. Strobes are high during cycle n+2.
- `data_movimento` and `addr_movimento` are stable while the strobes are high. `addr_movimento` increments at the edge ending GRAVA.
- A downstream counter fed by `conta_movimento` therefore tracks `addr_movimento` exactly.
- Terminator byte → `pronto` high 2 cycles after the receiver pulse.
- Worst-case byte throughput: one byte per 10·CLKS_PER_BIT cycles. The FSM returns to AGUARDA_BYTE within 3 cycles, so no byte loss at line rate.
- Receiver: two-flop synchroniser on `rx_serial`; start bit confirmed at half-bit; data sampled at bit centres; framing error (stop bit 0) → byte discarded, no `pronto`.

## Structure
- Shared package `rubiks_pkg`, holding:
  - state encodings;
  - constants `REQ_BYTE`=0x4D, `TERM_BYTE`=0x23, `MOV_BASE`=0x30, `N_MOV_CODES`=6;
  - the default CLKS_PER_BIT.
- Sub-module `uart_rx_8n1` (parameter CLKS_PER_BIT): ports `clock`, `reset`, `rx`, `dado[7:0]`, `pronto`. It is reusable by the image interface.
- The transmit shifter is small enough to stay inline.

## Test plan
- Reset, then `iniciar`: `saida_serial` carries 0x4D (bits 1,0,1,1,0,0,1,0 after start); `db_estado` goes 1 then 2.
- Send "0","3","5","#": three writes at addresses 0,1,2 with data 0,3,5; `pronto`=1, `num_movimentos`=3, `erro`=0.
- Send "2","X","4","#": writes 2 then 4 at addresses 0,1; `erro`=1; `num_movimentos`=2.
- Send 481 × "1": 480 writes, then `erro`=1 and `pronto`=1 with `num_movimentos`=480; the 481st byte produces no strobe.
- Assert `reset` mid-frame during the second received byte: outputs return to reset values immediately; a subsequent `iniciar` restarts cleanly at address 0.
- Corrupted stop bit on "4": no write; the next valid "1" is written at the same address.
